// File: rtl/peterson_pkg.sv
// peterson_pkg: shared types and default fairness bounds for the Peterson mutex model and its scheduler.
package peterson_pkg;
    typedef enum logic [2:0] {L0, L1, L2, L3, L4, L5} loc_t;
    typedef logic proc_id_t;
    localparam int DEF_MAX_WAIT  = 3;
    localparam int DEF_MAX_PAUSE = 2;
endpackage

// File: rtl/peterson_sat_cnt.sv
// peterson_sat_cnt: saturating up-counter with synchronous clear and hold.
module peterson_sat_cnt #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    always_ff @(posedge i_clk)
        if (i_rst || i_clr)
            r_q <= '0;
        else if (i_inc)
            r_q <= (r_q == W'(MAX)) ? r_q : r_q + 1'b1;
    assign o_q = r_q;
endmodule

// File: rtl/peterson_sched.sv
// peterson_sched: bounded-fair select/pause scheduler for the two-process Peterson model.
// Fairness overrides exist only when PETERSON_SCHED_FAIRNESS_EN is defined; otherwise inputs are just registered.
module peterson_sched
    import peterson_pkg::*;
#(
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int MAX_PAUSE = DEF_MAX_PAUSE
) (
    input  logic clock,
    input  logic reset,
    input  logic nd_select,
    input  logic nd_pause,
    output logic select,
    output logic pause,
    output logic forced
);
    proc_id_t w_sel;
    logic     w_pz;
    logic     w_f;
`ifdef PETERSON_SCHED_FAIRNESS_EN
    localparam int CW = $clog2((MAX_WAIT > MAX_PAUSE ? MAX_WAIT : MAX_PAUSE) + 1);
    logic [CW-1:0] w_wait  [2];
    logic [CW-1:0] w_pause [2];
    logic          w_fsel;
    logic          w_fpz;
    always_comb begin
        w_fsel = w_wait[~nd_select] == CW'(MAX_WAIT);
        w_sel  = w_fsel ? ~nd_select : nd_select;
        w_fpz  = nd_pause && (w_pause[w_sel] == CW'(MAX_PAUSE));
        w_pz   = nd_pause && !w_fpz;
        w_f    = w_fsel || w_fpz;
    end
    // The selected process resets its wait count and advances or clears its pause run;
    // the other one ages its wait count and keeps its pause run.
    for (genvar i = 0; i < 2; i++) begin : g_cnt
        peterson_sat_cnt #(.W(CW), .MAX(MAX_WAIT)) u_wait (
            .i_clk(clock),
            .i_rst(reset),
            .i_clr(w_sel == proc_id_t'(i)),
            .i_inc(w_sel != proc_id_t'(i)),
            .o_q  (w_wait[i])
        );
        peterson_sat_cnt #(.W(CW), .MAX(MAX_PAUSE)) u_pause (
            .i_clk(clock),
            .i_rst(reset),
            .i_clr(w_sel == proc_id_t'(i) && !w_pz),
            .i_inc(w_sel == proc_id_t'(i) && w_pz),
            .o_q  (w_pause[i])
        );
    end
`else
    assign w_sel = nd_select;
    assign w_pz  = nd_pause;
    assign w_f   = 1'b0;
`endif
    always_ff @(posedge clock)
        if (reset) begin
            select <= 1'b0;
            pause  <= 1'b0;
            forced <= 1'b0;
        end else begin
            select <= w_sel;
            pause  <= w_pz;
            forced <= w_f;
        end
endmodule

// File: tb/tb_peterson_sched.sv
// tb_peterson_sched: random and directed stimulus checked against a rule-level scheduler model.
module tb_peterson_sched;
    localparam int MAX_WAIT  = 3;
    localparam int MAX_PAUSE = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic nd_select = 1'b0;
    logic nd_pause = 1'b0;
    logic select, pause, forced;

    int n_vec = 0;
    int n_err = 0;

    int   m_wait [2];
    int   m_run  [2];
    logic e_sel, e_pz, e_f;

    peterson_sched #(.MAX_WAIT(MAX_WAIT), .MAX_PAUSE(MAX_PAUSE)) dut (
        .clock    (clock),
        .reset    (reset),
        .nd_select(nd_select),
        .nd_pause (nd_pause),
        .select   (select),
        .pause    (pause),
        .forced   (forced)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic s, input logic p, input logic r);
`ifdef PETERSON_SCHED_FAIRNESS_EN
        int sel;
`endif
        if (r) begin
            m_wait = '{0, 0};
            m_run  = '{0, 0};
            e_sel = 1'b0; e_pz = 1'b0; e_f = 1'b0;
            return;
        end
`ifdef PETERSON_SCHED_FAIRNESS_EN
        sel = int'(s);
        e_f = 1'b0;
        if (m_wait[1-sel] == MAX_WAIT) begin
            sel = 1 - sel;
            e_f = 1'b1;
        end
        e_pz = p;
        if (p && m_run[sel] == MAX_PAUSE) begin
            e_pz = 1'b0;
            e_f  = 1'b1;
        end
        m_wait[1-sel] = (m_wait[1-sel] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[1-sel] + 1;
        m_wait[sel]   = 0;
        m_run[sel]    = e_pz ? m_run[sel] + 1 : 0;
        e_sel = (sel == 1);
`else
        e_sel = s; e_pz = p; e_f = 1'b0;
`endif
    endtask

    task automatic step(input logic s, input logic p, input logic r);
        nd_select = s; nd_pause = p; reset = r;
        @(posedge clock);
        #1;
        model(s, p, r);
        chk("select", 8'(select), 8'(e_sel));
        chk("pause", 8'(pause), 8'(e_pz));
        chk("forced", 8'(forced), 8'(e_f));
    endtask

    initial begin
        logic s;
        // reset with arbitrary inputs, then first free cycle passes inputs through
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("rst_sel", 8'(select), 8'h0);
        chk("rst_pause", 8'(pause), 8'h0);
        chk("rst_forced", 8'(forced), 8'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("release_sel", 8'(select), 8'h1);
        chk("release_pause", 8'(pause), 8'h1);

        // starvation bound
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
`ifdef PETERSON_SCHED_FAIRNESS_EN
            chk("starve_sel", 8'(select), (i % 4 == 3) ? 8'h1 : 8'h0);
            chk("starve_forced", 8'(forced), (i % 4 == 3) ? 8'h1 : 8'h0);
`else
            chk("pass_sel", 8'(select), 8'h0);
`endif
        end

        // pause bound
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);

        // simultaneous override
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
`ifdef PETERSON_SCHED_FAIRNESS_EN
        chk("simul_sel", 8'(select), 8'h1);
        chk("simul_pause", 8'(pause), 8'h0);
        chk("simul_forced", 8'(forced), 8'h1);
`else
        chk("simul_sel", 8'(select), 8'h0);
        chk("simul_pause", 8'(pause), 8'h1);
`endif

        // reset mid-operation restarts the fairness window
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
`ifdef PETERSON_SCHED_FAIRNESS_EN
            chk("midrst_sel", 8'(select), (i == 3) ? 8'h1 : 8'h0);
`else
            chk("midrst_sel", 8'(select), 8'h0);
`endif
        end

        // random, with sticky nd_select to provoke starvation overrides
        s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) s = 1'($urandom);
            step(s, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
